// File: rtl/crc_gate_fifo.sv
// crc_gate_fifo: store-and-forward RX FIFO that releases only CRC-good frames downstream.
// Define CRC_GATE_STATS_EN to build the good/bad/overflow frame counters (tied to 0 otherwise).
module crc_gate_fifo #(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_USER_WIDTH = 80,
  parameter int P_DEPTH      = 512,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [P_DATA_WIDTH-1:0]   s_axis_rdata,
  input  logic [P_USER_WIDTH-1:0]   s_axis_ruser,
  input  logic [P_DATA_WIDTH/8-1:0] s_axis_rkeep,
  input  logic                      s_axis_rlast,
  input  logic                      s_axis_rvalid,
  input  logic                      i_crc_valid,
  input  logic                      i_crc_error,
  output logic [P_DATA_WIDTH-1:0]   m_axis_rdata,
  output logic [P_USER_WIDTH-1:0]   m_axis_ruser,
  output logic [P_DATA_WIDTH/8-1:0] m_axis_rkeep,
  output logic                      m_axis_rlast,
  output logic                      m_axis_rvalid,
  input  logic                      m_axis_rready,
  output logic [P_CNT_WIDTH-1:0]    o_good_cnt,
  output logic [P_CNT_WIDTH-1:0]    o_bad_cnt,
  output logic [P_CNT_WIDTH-1:0]    o_ovf_cnt
);
  localparam int KW = P_DATA_WIDTH/8;
  localparam int AW = $clog2(P_DEPTH);

  typedef logic [AW:0] ptr_t;
  typedef struct packed {
    logic [P_DATA_WIDTH-1:0] data;
    logic [P_USER_WIDTH-1:0] user;
    logic [KW-1:0]           keep;
    logic                    last;
  } beat_t;
  typedef enum logic [1:0] {IDLE, RECV, DISCARD, WAIT_CRC} state_t;

  beat_t      mem [P_DEPTH];
  state_t     state, state_nxt;
  ptr_t       wr_ptr, wr_ptr_nxt, commit_ptr, commit_nxt, rd_ptr;
  logic       drop, drop_nxt, coll, coll_nxt;
  logic       wr_en, verdict, good_inc, bad_inc;
  logic [1:0] ovf_add;
  logic       beat_in, last_in, full;

  assign beat_in = s_axis_rvalid;
  assign last_in = s_axis_rvalid & s_axis_rlast;
  assign full    = (wr_ptr - rd_ptr) == ptr_t'(P_DEPTH);

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    drop_nxt   = drop;
    coll_nxt   = coll;
    wr_en      = 1'b0;
    verdict    = 1'b0;
    good_inc   = 1'b0;
    bad_inc    = 1'b0;
    ovf_add    = 2'd0;
    // A frame that starts while a verdict is pending is tracked apart and dropped whole.
    if (beat_in && (coll || state == WAIT_CRC)) begin
      coll_nxt = !last_in;
      if (last_in) ovf_add = 2'd1;
    end
    case (state)
      IDLE, RECV: if (beat_in && !coll) begin
        if (full) begin
          drop_nxt  = 1'b1;
          state_nxt = last_in ? WAIT_CRC : DISCARD;
        end else begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + ptr_t'(1);
          state_nxt  = last_in ? WAIT_CRC : RECV;
        end
        verdict = last_in;
      end
      DISCARD: if (last_in) begin
        state_nxt = WAIT_CRC;
        verdict   = 1'b1;
      end
      WAIT_CRC: verdict = 1'b1;
      default:  state_nxt = IDLE;
    endcase
    if (verdict && i_crc_valid) begin
      if (drop_nxt) begin
        wr_ptr_nxt = commit_ptr;
        ovf_add    = ovf_add + 2'd1;
      end else if (i_crc_error) begin
        wr_ptr_nxt = commit_ptr;
        bad_inc    = 1'b1;
      end else begin
        commit_nxt = wr_ptr_nxt;
        good_inc   = 1'b1;
      end
      drop_nxt  = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop       <= 1'b0;
      coll       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      drop       <= drop_nxt;
      coll       <= coll_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_rdata, s_axis_ruser, s_axis_rkeep, s_axis_rlast};
  end

  // Read side: RAM read lands in the output register, or in the skid when the output is stalled.
  beat_t out_q, skid_q, rd_data;
  logic  out_vld, skid_vld, rd_en, pop;

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign pop     = out_vld & m_axis_rready;
  assign rd_en   = (rd_ptr != commit_ptr) && !skid_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr   <= '0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
      if (skid_vld) begin
        if (pop || !out_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end
      end else if (rd_en) begin
        if (pop || !out_vld) begin
          out_q   <= rd_data;
          out_vld <= 1'b1;
        end else begin
          skid_q   <= rd_data;
          skid_vld <= 1'b1;
        end
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign m_axis_rvalid = out_vld;
  assign m_axis_rdata  = out_q.data;
  assign m_axis_ruser  = out_q.user;
  assign m_axis_rkeep  = out_q.keep;
  assign m_axis_rlast  = out_q.last;

`ifdef CRC_GATE_STATS_EN
  logic [P_CNT_WIDTH-1:0] good_cnt, bad_cnt, ovf_cnt;

  function automatic logic [P_CNT_WIDTH-1:0] sat_add(input logic [P_CNT_WIDTH-1:0] c,
                                                     input logic [1:0] a);
    logic [P_CNT_WIDTH+1:0] s;
    s = {2'b00, c} + {{P_CNT_WIDTH{1'b0}}, a};
    return (s > {2'b00, {P_CNT_WIDTH{1'b1}}}) ? '1 : s[P_CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      ovf_cnt  <= '0;
    end else begin
      good_cnt <= sat_add(good_cnt, {1'b0, good_inc});
      bad_cnt  <= sat_add(bad_cnt, {1'b0, bad_inc});
      ovf_cnt  <= sat_add(ovf_cnt, ovf_add);
    end
  end

  assign o_good_cnt = good_cnt;
  assign o_bad_cnt  = bad_cnt;
  assign o_ovf_cnt  = ovf_cnt;
`else
  logic unused_stats;
  assign unused_stats = ^{good_inc, bad_inc, ovf_add};
  assign o_good_cnt   = '0;
  assign o_bad_cnt    = '0;
  assign o_ovf_cnt    = '0;
`endif

endmodule

// File: tb/tb_crc_gate_fifo.sv
// tb_crc_gate_fifo: directed scoreboard bench for crc_gate_fifo built with a 16-beat FIFO.
`timescale 1ns/1ps
module tb_crc_gate_fifo;
  localparam int DW = 64, UW = 80, KW = 8, CW = 16;
  localparam int EW = DW + UW + KW + 1;
`ifdef CRC_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] s_axis_rdata = '0;
  logic [UW-1:0] s_axis_ruser = '0;
  logic [KW-1:0] s_axis_rkeep = '0;
  logic          s_axis_rlast = 1'b0, s_axis_rvalid = 1'b0;
  logic          i_crc_valid = 1'b0, i_crc_error = 1'b0;
  logic [DW-1:0] m_axis_rdata;
  logic [UW-1:0] m_axis_ruser;
  logic [KW-1:0] m_axis_rkeep;
  logic          m_axis_rlast, m_axis_rvalid;
  logic          m_axis_rready = 1'b0;
  logic [CW-1:0] o_good_cnt, o_bad_cnt, o_ovf_cnt;

  crc_gate_fifo #(.P_DATA_WIDTH(DW), .P_USER_WIDTH(UW), .P_DEPTH(16), .P_CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_axis_rdata(s_axis_rdata), .s_axis_ruser(s_axis_ruser), .s_axis_rkeep(s_axis_rkeep),
    .s_axis_rlast(s_axis_rlast), .s_axis_rvalid(s_axis_rvalid),
    .i_crc_valid(i_crc_valid), .i_crc_error(i_crc_error),
    .m_axis_rdata(m_axis_rdata), .m_axis_ruser(m_axis_ruser), .m_axis_rkeep(m_axis_rkeep),
    .m_axis_rlast(m_axis_rlast), .m_axis_rvalid(m_axis_rvalid), .m_axis_rready(m_axis_rready),
    .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [EW-1:0] sb[$];
  bit tx_done = 1'b0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] cexp(input int n);
    return STATS ? EW'(n) : '0;
  endfunction

  function automatic logic [EW-1:0] mk_beat(input int fid, input int idx, input bit last,
                                            input logic [KW-1:0] keep);
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    d = {fid[15:0], idx[15:0], $urandom()};
    u = {fid[15:0], $urandom(), $urandom()};
    return {d, u, keep, last};
  endfunction

  task automatic drive(input logic [EW-1:0] b, input bit vld, input bit cv, input bit ce);
    {s_axis_rdata, s_axis_ruser, s_axis_rkeep, s_axis_rlast} = b;
    s_axis_rvalid = vld;
    i_crc_valid   = cv;
    i_crc_error   = ce;
    @(posedge i_clk); #1;
    s_axis_rvalid = 1'b0;
    i_crc_valid   = 1'b0;
    i_crc_error   = 1'b0;
  endtask

  task automatic send_frame(input int fid, input int nb, input logic [KW-1:0] klast, input bit push);
    logic [EW-1:0] b;
    for (int i = 0; i < nb; i++) begin
      b = mk_beat(fid, i, i == nb - 1, (i == nb - 1) ? klast : '1);
      if (push) sb.push_back(b);
      drive(b, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic verdict(input bit err);
    drive('0, 1'b0, 1'b1, err);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge i_clk); #1;
      k++;
    end
    chk(tag, EW'(sb.size()), '0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rvalid"}, EW'(m_axis_rvalid), '0);
    chk({tag, "_rdata"}, EW'(m_axis_rdata), '0);
    chk({tag, "_ruser"}, EW'(m_axis_ruser), '0);
    chk({tag, "_rkeep"}, EW'(m_axis_rkeep), '0);
    chk({tag, "_rlast"}, EW'(m_axis_rlast), '0);
    chk({tag, "_good"}, EW'(o_good_cnt), '0);
    chk({tag, "_bad"}, EW'(o_bad_cnt), '0);
    chk({tag, "_ovf"}, EW'(o_ovf_cnt), '0);
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stalled beats hold still.
  logic [EW-1:0] mon_cur, mon_prev;
  bit mon_hold = 1'b0;
  always @(negedge i_clk) begin
    mon_cur = {m_axis_rdata, m_axis_ruser, m_axis_rkeep, m_axis_rlast};
    if (i_rst) begin
      mon_hold = 1'b0;
    end else begin
      if (mon_hold) begin
        chk("hold_valid", EW'(m_axis_rvalid), EW'(1));
        chk("hold_data", mon_cur, mon_prev);
      end
      if (m_axis_rvalid && m_axis_rready) begin
        if (sb.size() == 0) chk("stray_beat", EW'(m_axis_rvalid), '0);
        else chk("beat", mon_cur, sb.pop_front());
      end
      mon_hold = m_axis_rvalid && !m_axis_rready;
      mon_prev = mon_cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] b;
    bit errs [6];
    errs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_outputs_zero("reset");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Good frame with first-beat latency
    m_axis_rready = 1'b1;
    send_frame(1, 10, 8'hF0, 1'b1);
    chk("t1_pre_verdict", EW'(m_axis_rvalid), '0);
    verdict(1'b0);
    @(negedge i_clk);
    chk("t1_lat1", EW'(m_axis_rvalid), '0);
    @(negedge i_clk);
    chk("t1_lat2", EW'(m_axis_rvalid), EW'(1));
    @(posedge i_clk); #1;
    wait_drain("t1_drain", 40);
    chk("t1_good", EW'(o_good_cnt), cexp(1));

    // Alternating verdicts
    for (int f = 0; f < 6; f++) begin
      send_frame(10 + f, 3, '1, !errs[f]);
      verdict(errs[f]);
    end
    wait_drain("t2_drain", 40);
    repeat (8) begin @(posedge i_clk); #1; end
    chk("t2_good", EW'(o_good_cnt), cexp(4));
    chk("t2_bad", EW'(o_bad_cnt), cexp(3));

    // Overflow of a 16-beat FIFO by a 20-beat frame
    m_axis_rready = 1'b0;
    send_frame(20, 20, '1, 1'b0);
    verdict(1'b0);
    repeat (5) begin @(posedge i_clk); #1; end
    chk("t3_no_out", EW'(m_axis_rvalid), '0);
    chk("t3_ovf", EW'(o_ovf_cnt), cexp(1));
    chk("t3_good_hold", EW'(o_good_cnt), cexp(4));
    m_axis_rready = 1'b1;
    send_frame(21, 4, 8'h0F, 1'b1);
    verdict(1'b0);
    wait_drain("t3_drain", 40);
    chk("t3_good", EW'(o_good_cnt), cexp(5));

    // Backpressure with rready toggling 1-0-0-1
    fork
      begin
        send_frame(30, 10, '1, 1'b1);
        verdict(1'b0);
        repeat (12) begin @(posedge i_clk); #1; end
        send_frame(31, 10, 8'h3F, 1'b1);
        verdict(1'b0);
        tx_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!(tx_done && sb.size() == 0) && k < 400) begin
          m_axis_rready = (k % 4 == 0) || (k % 4 == 3);
          @(posedge i_clk); #1;
          k++;
        end
        m_axis_rready = 1'b1;
      end
    join
    chk("t4_drain", EW'(sb.size()), '0);
    chk("t4_good", EW'(o_good_cnt), cexp(7));

    // Collision: second frame starts while the first awaits its verdict
    for (int i = 0; i < 4; i++) begin
      b = mk_beat(40, i, i == 3, '1);
      sb.push_back(b);
      drive(b, 1'b1, 1'b0, 1'b0);
    end
    drive(mk_beat(41, 0, 1'b0, '1), 1'b1, 1'b0, 1'b0);
    drive(mk_beat(41, 1, 1'b0, '1), 1'b1, 1'b1, 1'b0);
    drive(mk_beat(41, 2, 1'b1, '1), 1'b1, 1'b0, 1'b0);
    wait_drain("t5_drain", 40);
    repeat (8) begin @(posedge i_clk); #1; end
    chk("t5_good", EW'(o_good_cnt), cexp(8));
    chk("t5_ovf", EW'(o_ovf_cnt), cexp(2));
    chk("t5_bad", EW'(o_bad_cnt), cexp(3));

    // Reset mid-frame with three committed frames unread
    m_axis_rready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_frame(50 + f, 3, '1, 1'b0);
      verdict(1'b0);
    end
    repeat (3) begin @(posedge i_clk); #1; end
    chk("t6_pending", EW'(m_axis_rvalid), EW'(1));
    drive(mk_beat(53, 0, 1'b0, '1), 1'b1, 1'b0, 1'b0);
    {s_axis_rdata, s_axis_ruser, s_axis_rkeep, s_axis_rlast} = mk_beat(53, 1, 1'b0, '1);
    s_axis_rvalid = 1'b1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk_outputs_zero("t6_rst");
    i_rst = 1'b0;
    s_axis_rvalid = 1'b0;
    m_axis_rready = 1'b1;
    send_frame(60, 3, 8'h01, 1'b1);
    verdict(1'b0);
    wait_drain("t6_drain", 40);
    repeat (10) begin @(posedge i_clk); #1; end
    chk("t6_good", EW'(o_good_cnt), cexp(1));
    chk("t6_bad", EW'(o_bad_cnt), '0);
    chk("t6_ovf", EW'(o_ovf_cnt), '0);
    chk("t6_idle", EW'(m_axis_rvalid), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
